// File: rtl/hsst_rst_pkg.sv
// Shared constants for the HSST reset release sequencer: sequencing modes
// and default hold-counter sizing.
package hsst_rst_pkg;

  localparam int SEQ_INDEP   = 0;
  localparam int SEQ_ORDERED = 1;

  localparam int          DEF_CNT_WIDTH   = 16;
  localparam int unsigned DEF_HOLD_CYCLES = 32'h0000_C000;

  // True when a hold count can be represented in a counter of the given width
  function automatic logic hold_fits(input int unsigned hold, input int cnt_width);
    logic [63:0] limit_v;
    limit_v = 64'd1 << cnt_width;
    return (64'(hold) < limit_v);
  endfunction

endpackage

// File: rtl/hsst_rst_chan_v1_0.sv
// One reset channel: request synchroniser, glitch filter, saturating hold
// counter and the registered active-low reset output.
module hsst_rst_chan_v1_0
  import hsst_rst_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 4,
  parameter int          CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_in,
  input  logic rstn_req,
  input  logic force_rst,
  input  logic en,
  output logic req_ok,
  output logic rstn_out
);

  localparam logic [CNT_WIDTH-1:0] HOLD_VAL = CNT_WIDTH'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   req_ok_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_nxt_s;
  logic                   rstn_out_r;
  logic                   rstn_nxt_s;

  // Synchroniser chain for the asynchronous request
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rstn_req};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // The filter window is the current synced sample plus FILT_LEN-1 history bits,
  // so req_ok sets on the edge that samples the FILT_LEN-th consecutive one.
  if (FILT_LEN == 1) begin : g_filt_one
    // Single-sample filter: request qualifies directly
    always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
        req_ok_r <= 1'b0;
      end else begin
        req_ok_r <= sync_s;
      end
    end
  end else begin : g_filt_shift
    logic [FILT_LEN-2:0] filt_r;
    logic [FILT_LEN-1:0] win_s;

    assign win_s = {filt_r, sync_s};

    // History shift register and all-ones qualification
    always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
        filt_r   <= {(FILT_LEN-1){1'b0}};
        req_ok_r <= 1'b0;
      end else begin
        filt_r   <= win_s[FILT_LEN-2:0];
        req_ok_r <= &win_s;
      end
    end
  end

  // Hold counter and output decision; saturates at HOLD_VAL instead of wrapping
  always_comb begin
    cnt_nxt_s  = cnt_r;
    rstn_nxt_s = 1'b0;
    if (!en || force_rst) begin
      cnt_nxt_s  = {CNT_WIDTH{1'b0}};
      rstn_nxt_s = 1'b0;
    end else if (cnt_r == HOLD_VAL) begin
      cnt_nxt_s  = cnt_r;
      rstn_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s  = cnt_r + CNT_WIDTH'(1'b1);
      rstn_nxt_s = 1'b0;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      cnt_r      <= {CNT_WIDTH{1'b0}};
      rstn_out_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      rstn_out_r <= rstn_nxt_s;
    end
  end

  assign req_ok   = req_ok_r;
  assign rstn_out = rstn_out_r;

endmodule

// File: rtl/hsst_rst_seq_mc_v1_0.sv
// Multi-channel reset release sequencer: per-channel filtered/held resets with
// optional strict index-order release, release pulses and a group-done flag.
module hsst_rst_seq_mc_v1_0
  import hsst_rst_pkg::*;
#(
  parameter int          CH_NUM      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 4,
  parameter int          CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int          SEQ_MODE    = SEQ_INDEP
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [CH_NUM-1:0] rstn_req,
  input  logic [CH_NUM-1:0] force_rst,
  output logic [CH_NUM-1:0] rstn_out,
  output logic [CH_NUM-1:0] rel_pulse,
  output logic              all_done
);

  if (!hold_fits(HOLD_CYCLES, CNT_WIDTH)) begin : g_chk_hold
    $error("HOLD_CYCLES does not fit in CNT_WIDTH bits");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 1) begin : g_chk_filt
    $error("FILT_LEN must be at least 1");
  end
  if ((CH_NUM < 1) || (CH_NUM > 16)) begin : g_chk_ch
    $error("CH_NUM must be in 1..16");
  end

  logic [CH_NUM-1:0] req_ok_s;
  logic [CH_NUM-1:0] en_s;
  logic [CH_NUM-1:0] rstn_out_s;
  logic [CH_NUM-1:0] rstn_out_d_r;
  logic [CH_NUM-1:0] rel_pulse_r;
  logic              all_done_r;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    // Ordered mode gates each channel on its predecessor's released output,
    // so a drop ripples up the chain one edge per channel.
    if ((SEQ_MODE == SEQ_ORDERED) && (i > 0)) begin : g_en_ord
      assign en_s[i] = req_ok_s[i] & rstn_out_s[i-1];
    end else begin : g_en_ind
      assign en_s[i] = req_ok_s[i];
    end

    hsst_rst_chan_v1_0 #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_WIDTH   (CNT_WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst_in    (rst_in),
      .rstn_req  (rstn_req[i]),
      .force_rst (force_rst[i]),
      .en        (en_s[i]),
      .req_ok    (req_ok_s[i]),
      .rstn_out  (rstn_out_s[i])
    );
  end

  // Release-edge pulses and group completion status
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rstn_out_d_r <= {CH_NUM{1'b0}};
      rel_pulse_r  <= {CH_NUM{1'b0}};
      all_done_r   <= 1'b0;
    end else begin
      rstn_out_d_r <= rstn_out_s;
      rel_pulse_r  <= rstn_out_s & ~rstn_out_d_r;
      all_done_r   <= &rstn_out_s;
    end
  end

  assign rstn_out  = rstn_out_s;
  assign rel_pulse = rel_pulse_r;
  assign all_done  = all_done_r;

endmodule

// File: tb/tb_hsst_rst_seq_mc_v1_0.sv
// Directed bench: one independent-mode and one ordered-mode instance share
// clock, reset and request inputs (CH_NUM=4, SYNC=2, FILT=4, HOLD=8).
module tb_hsst_rst_seq_mc_v1_0;

  logic       clk;
  logic       rst_in;
  logic [3:0] rstn_req;
  logic [3:0] force_rst;
  logic [3:0] ind_out, ind_pulse, ord_out, ord_pulse;
  logic       ind_done, ord_done;

  int total = 0;
  int bad   = 0;

  hsst_rst_seq_mc_v1_0 #(
    .CH_NUM(4), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_WIDTH(8),
    .HOLD_CYCLES(8), .SEQ_MODE(0)
  ) u_ind (
    .clk(clk), .rst_in(rst_in), .rstn_req(rstn_req), .force_rst(force_rst),
    .rstn_out(ind_out), .rel_pulse(ind_pulse), .all_done(ind_done)
  );

  hsst_rst_seq_mc_v1_0 #(
    .CH_NUM(4), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_WIDTH(8),
    .HOLD_CYCLES(8), .SEQ_MODE(1)
  ) u_ord (
    .clk(clk), .rst_in(rst_in), .rstn_req(rstn_req), .force_rst(force_rst),
    .rstn_out(ord_out), .rel_pulse(ord_pulse), .all_done(ord_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_in = 1'b1; rstn_req = 4'h0; force_rst = 4'h0;
    #3;
    total++; if (ind_out !== 4'h0) begin bad++; $display("FAIL reset_ind_out got=%h exp=0", ind_out); end
    total++; if (ind_pulse !== 4'h0) begin bad++; $display("FAIL reset_ind_pulse got=%h exp=0", ind_pulse); end
    total++; if (ind_done !== 1'b0) begin bad++; $display("FAIL reset_ind_done got=%b exp=0", ind_done); end
    total++; if (ord_out !== 4'h0) begin bad++; $display("FAIL reset_ord_out got=%h exp=0", ord_out); end
    total++; if (ord_done !== 1'b0) begin bad++; $display("FAIL reset_ord_done got=%b exp=0", ord_done); end
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ind_out !== 4'h0) begin bad++; $display("FAIL idle_ind_out got=%h exp=0", ind_out); end
  endtask

  // All requests rise together; edges counted from the negedge the requests change
  task automatic test_release();
    logic [3:0] exp_o, exp_p;
    rstn_req = 4'hF;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk);
      exp_o = (e >= 15) ? 4'hF : 4'h0;
      exp_p = (e == 16) ? 4'hF : 4'h0;
      total++; if (ind_out !== exp_o) begin bad++; $display("FAIL rel_ind_out e=%0d got=%h exp=%h", e, ind_out, exp_o); end
      total++; if (ind_pulse !== exp_p) begin bad++; $display("FAIL rel_ind_pulse e=%0d got=%h exp=%h", e, ind_pulse, exp_p); end
      total++; if (ind_done !== (e >= 16)) begin bad++; $display("FAIL rel_ind_done e=%0d got=%b", e, ind_done); end
      for (int k = 0; k < 4; k++) begin
        exp_o[k] = (e >= 15 + 9 * k);
        exp_p[k] = (e == 16 + 9 * k);
      end
      total++; if (ord_out !== exp_o) begin bad++; $display("FAIL rel_ord_out e=%0d got=%h exp=%h", e, ord_out, exp_o); end
      total++; if (ord_pulse !== exp_p) begin bad++; $display("FAIL rel_ord_pulse e=%0d got=%h exp=%h", e, ord_pulse, exp_p); end
      total++; if (ord_done !== (e >= 43)) begin bad++; $display("FAIL rel_ord_done e=%0d got=%b", e, ord_done); end
    end
  endtask

  task automatic test_async_reset();
    #2 rst_in = 1'b1;
    #1;
    total++; if (ind_out !== 4'h0) begin bad++; $display("FAIL arst_ind_out got=%h exp=0", ind_out); end
    total++; if (ind_done !== 1'b0) begin bad++; $display("FAIL arst_ind_done got=%b exp=0", ind_done); end
    total++; if (ord_out !== 4'h0) begin bad++; $display("FAIL arst_ord_out got=%h exp=0", ord_out); end
    total++; if (ord_done !== 1'b0) begin bad++; $display("FAIL arst_ord_done got=%b exp=0", ord_done); end
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (ind_out !== 4'h0) begin bad++; $display("FAIL midcnt_ind_out got=%h exp=0", ind_out); end
    // Short pulse between edges: count must restart from zero
    #2 rst_in = 1'b1;
    #1;
    total++; if (ind_out !== 4'h0) begin bad++; $display("FAIL midpulse_ind_out got=%h exp=0", ind_out); end
    #1 rst_in = 1'b0;
    repeat (14) @(negedge clk);
    total++; if (ind_out !== 4'h0) begin bad++; $display("FAIL restart_e14 got=%h exp=0", ind_out); end
    @(negedge clk);
    total++; if (ind_out !== 4'hF) begin bad++; $display("FAIL restart_e15 got=%h exp=f", ind_out); end
    repeat (28) @(negedge clk);
    total++; if (ord_out !== 4'hF) begin bad++; $display("FAIL restart_ord_out got=%h exp=f", ord_out); end
    total++; if (ord_done !== 1'b1) begin bad++; $display("FAIL restart_ord_done got=%b exp=1", ord_done); end
  endtask

  task automatic test_glitch();
    rstn_req[2] = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ind_out !== 4'hF) begin bad++; $display("FAIL drop_e3 got=%h exp=f", ind_out); end
    @(negedge clk);
    total++; if (ind_out !== 4'hB) begin bad++; $display("FAIL drop_e4 got=%h exp=b", ind_out); end
    repeat (6) @(negedge clk);
    rstn_req[2] = 1'b1;
    repeat (3) @(negedge clk);
    rstn_req[2] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      total++; if (ind_out !== 4'hB) begin bad++; $display("FAIL glitch e=%0d got=%h exp=b", e, ind_out); end
    end
    rstn_req[2] = 1'b1;
    repeat (14) @(negedge clk);
    total++; if (ind_out !== 4'hB) begin bad++; $display("FAIL stable_e14 got=%h exp=b", ind_out); end
    @(negedge clk);
    total++; if (ind_out !== 4'hF) begin bad++; $display("FAIL stable_e15 got=%h exp=f", ind_out); end
    repeat (10) @(negedge clk);
    total++; if (ord_out !== 4'hF) begin bad++; $display("FAIL stable_ord_out got=%h exp=f", ord_out); end
    total++; if (ord_done !== 1'b1) begin bad++; $display("FAIL stable_ord_done got=%b exp=1", ord_done); end
  endtask

  task automatic test_ordered_drop();
    rstn_req[1] = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ord_out !== 4'hF) begin bad++; $display("FAIL odrop_e3 got=%h exp=f", ord_out); end
    @(negedge clk);
    total++; if (ord_out !== 4'hD) begin bad++; $display("FAIL odrop_e4 got=%h exp=d", ord_out); end
    total++; if (ord_done !== 1'b1) begin bad++; $display("FAIL odrop_done_e4 got=%b exp=1", ord_done); end
    total++; if (ind_out !== 4'hD) begin bad++; $display("FAIL idrop_e4 got=%h exp=d", ind_out); end
    @(negedge clk);
    total++; if (ord_out !== 4'h9) begin bad++; $display("FAIL odrop_e5 got=%h exp=9", ord_out); end
    total++; if (ord_done !== 1'b0) begin bad++; $display("FAIL odrop_done_e5 got=%b exp=0", ord_done); end
    total++; if (ind_out !== 4'hD) begin bad++; $display("FAIL idrop_e5 got=%h exp=d", ind_out); end
    @(negedge clk);
    total++; if (ord_out !== 4'h1) begin bad++; $display("FAIL odrop_e6 got=%h exp=1", ord_out); end
    @(negedge clk);
    total++; if (ord_out !== 4'h1) begin bad++; $display("FAIL odrop_e7 got=%h exp=1", ord_out); end
    rstn_req[1] = 1'b1;
    repeat (32) @(negedge clk);
    total++; if (ord_out !== 4'h7) begin bad++; $display("FAIL orel_e32 got=%h exp=7", ord_out); end
    @(negedge clk);
    total++; if (ord_out !== 4'hF) begin bad++; $display("FAIL orel_e33 got=%h exp=f", ord_out); end
    total++; if (ind_out !== 4'hF) begin bad++; $display("FAIL irel_e33 got=%h exp=f", ind_out); end
    @(negedge clk);
  endtask

  task automatic test_force();
    force_rst = 4'h8;
    @(negedge clk);
    force_rst = 4'h0;
    total++; if (ind_out !== 4'h7) begin bad++; $display("FAIL force_ind got=%h exp=7", ind_out); end
    total++; if (ord_out !== 4'h7) begin bad++; $display("FAIL force_ord got=%h exp=7", ord_out); end
    total++; if (ind_done !== 1'b1) begin bad++; $display("FAIL force_done_e1 got=%b exp=1", ind_done); end
    @(negedge clk);
    total++; if (ind_done !== 1'b0) begin bad++; $display("FAIL force_done_e2 got=%b exp=0", ind_done); end
    repeat (7) @(negedge clk);
    total++; if (ind_out !== 4'h7) begin bad++; $display("FAIL force_hold_r8 got=%h exp=7", ind_out); end
    total++; if (ord_out !== 4'h7) begin bad++; $display("FAIL force_hold_ord_r8 got=%h exp=7", ord_out); end
    @(negedge clk);
    total++; if (ind_out !== 4'hF) begin bad++; $display("FAIL force_rel_r9 got=%h exp=f", ind_out); end
    total++; if (ord_out !== 4'hF) begin bad++; $display("FAIL force_rel_ord_r9 got=%h exp=f", ord_out); end
    @(negedge clk);
    total++; if (ind_pulse !== 4'h8) begin bad++; $display("FAIL force_pulse got=%h exp=8", ind_pulse); end
    total++; if (ord_pulse !== 4'h8) begin bad++; $display("FAIL force_pulse_ord got=%h exp=8", ord_pulse); end
    total++; if (ind_done !== 1'b1) begin bad++; $display("FAIL force_done_r10 got=%b exp=1", ind_done); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_async_reset();
    test_glitch();
    test_ordered_drop();
    test_force();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
